// File: rtl/store_buffer.sv
// Posted-write store buffer between the core MEM stage and data memory.
// Stores queue in a FIFO, drain over a req/ack port, and forward to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    input  logic [AW-1:0]            ld_adr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    adr_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_enq;
    logic             do_deq;
    logic [PW-1:0]    idx;
    logic             ld_adr_unused;

    // Full/empty come only from the registered count; no same-cycle bypass.
    assign stall   = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign mem_req = (count != '0);
    assign do_enq  = memwrite && !stall;
    assign do_deq  = mem_req && mem_ack;

    assign mem_adr   = mem_req ? adr_q[rd_ptr]  : '0;
    assign mem_wdata = mem_req ? data_q[rd_ptr] : '0;

    assign ld_adr_unused = ^ld_adr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_enq) begin
                adr_q[wr_ptr]   <= dataadr;
                data_q[wr_ptr]  <= writedata;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (do_enq && !do_deq)
                count <= count + 1'b1;
            else if (do_deq && !do_enq)
                count <= count - 1'b1;
        end
    end

    // Walk from oldest to youngest so the youngest matching store wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PW'(k);
            if (valid_q[idx] && (adr_q[idx][AW-1:2] == ld_adr[AW-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: reset, fill/stall, ordering,
// forwarding, pointer wrap and asynchronous reset during a drain.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   memwrite;
    logic [AW-1:0]          dataadr;
    logic [DW-1:0]          writedata;
    logic                   stall;
    logic [AW-1:0]          ld_adr;
    logic                   ld_hit;
    logic [DW-1:0]          ld_data;
    logic                   mem_req;
    logic [AW-1:0]          mem_adr;
    logic [DW-1:0]          mem_wdata;
    logic                   mem_ack;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;

    int nvectors = 0;
    int nmiss    = 0;

    logic [AW-1:0] exp_adr [4];
    logic [DW-1:0] exp_dat [4];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .ld_adr(ld_adr), .ld_hit(ld_hit),
        .ld_data(ld_data), .mem_req(mem_req), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvectors++;
        if (got !== exp) begin
            nmiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so inputs/outputs are away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic pushStore(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        applyStimulus();
        memwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        ld_adr = '0; mem_ack = 1'b0;
        #12;
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_memreq", mem_req, 0);
        checkOutput("rst_ldhit", ld_hit, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_memadr", mem_adr, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();

        // single store then ack
        pushStore(32'h8, 32'h04ee9112);
        checkOutput("single_req", mem_req, 1);
        checkOutput("single_adr", mem_adr, 32'h8);
        checkOutput("single_dat", mem_wdata, 32'h04ee9112);
        checkOutput("single_cnt", count, 1);
        ld_adr = 32'h8;
        #1;
        checkOutput("single_fwd_hit", ld_hit, 1);
        checkOutput("single_fwd_dat", ld_data, 32'h04ee9112);
        mem_ack = 1'b1;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("single_req_after", mem_req, 0);
        checkOutput("single_empty", empty, 1);
        checkOutput("single_fwd_gone", ld_hit, 0);

        // fill, refuse fifth, drain in order
        for (int i = 0; i < 4; i++) pushStore(32'(4 * i), 32'hA0 + 32'(i));
        checkOutput("fill_cnt", count, 4);
        checkOutput("fill_stall", stall, 1);
        pushStore(32'h10, 32'hDEAD);
        checkOutput("fifth_refused_cnt", count, 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_adr", mem_adr, 32'(4 * i));
            checkOutput("drain_dat", mem_wdata, 32'hA0 + 32'(i));
            mem_ack = 1'b1;
            applyStimulus();
            mem_ack = 1'b0;
        end
        checkOutput("drain_empty", empty, 1);

        // full + ack + store in the same cycle
        for (int i = 0; i < 4; i++) pushStore(32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
        memwrite = 1'b1; dataadr = 32'h200; writedata = 32'hC0; mem_ack = 1'b1;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("fullack_cnt", count, 3);
        checkOutput("fullack_stall", stall, 0);
        applyStimulus();
        memwrite = 1'b0;
        checkOutput("held_store_cnt", count, 4);
        checkOutput("held_store_stall", stall, 1);
        exp_adr = '{32'h104, 32'h108, 32'h10C, 32'h200};
        exp_dat = '{32'hB1, 32'hB2, 32'hB3, 32'hC0};
        for (int i = 0; i < 4; i++) begin
            checkOutput("order_adr", mem_adr, exp_adr[i]);
            checkOutput("order_dat", mem_wdata, exp_dat[i]);
            mem_ack = 1'b1;
            applyStimulus();
            mem_ack = 1'b0;
        end
        checkOutput("order_empty", empty, 1);

        // forwarding picks the youngest match
        pushStore(32'h40, 32'h11111111);
        pushStore(32'h40, 32'h22222222);
        ld_adr = 32'h42;
        #1;
        checkOutput("fwd_hit", ld_hit, 1);
        checkOutput("fwd_young", ld_data, 32'h22222222);
        ld_adr = 32'h44;
        #1;
        checkOutput("fwd_miss", ld_hit, 0);
        checkOutput("fwd_miss_dat", ld_data, 0);
        mem_ack = 1'b1;
        applyStimulus();
        ld_adr = 32'h40;
        #1;
        checkOutput("fwd_after_pop", ld_data, 32'h22222222);
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("fwd_drained", empty, 1);

        // wrap-around with a store and an ack every cycle
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            memwrite = 1'b1; dataadr = 32'h300 + 32'(4 * i); writedata = 32'hD00 + 32'(i);
            applyStimulus();
            checkOutput("wrap_cnt", count, 1);
            checkOutput("wrap_adr", mem_adr, 32'h300 + 32'(4 * i));
            checkOutput("wrap_dat", mem_wdata, 32'hD00 + 32'(i));
        end
        memwrite = 1'b0;
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("wrap_empty", empty, 1);

        // asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) pushStore(32'h500 + 32'(4 * i), 32'hE0 + 32'(i));
        checkOutput("pre_rst_cnt", count, 3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_req", mem_req, 0);
        checkOutput("async_rst_cnt", count, 0);
        checkOutput("async_rst_empty", empty, 1);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        applyStimulus();
        applyStimulus();
        mem_ack = 1'b0;
        checkOutput("post_rst_req", mem_req, 0);
        checkOutput("post_rst_adr", mem_adr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvectors, nmiss);
        $finish;
    end

endmodule
